// File: rtl/mem_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_refill_arbiter
// Description : Shares one main-memory port between the ICache refill engine
//               and the DCache refill/writeback engine, one line burst at a
//               time. Define MEM_ARB_RR_EN for round-robin tie breaking;
//               otherwise DCache has fixed priority over ICache.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_refill_arbiter #(
    parameter int ADDR_LEN       = 32,
    parameter int LINE_WORDS_LOG = 3
) (
    input  logic                clk,
    input  logic                CpuRstN,
    input  logic                IReq,
    input  logic [ADDR_LEN-1:0] IAddr,
    output logic                IGnt,
    output logic [31:0]         IRdata,
    output logic                IRvalid,
    output logic                IDone,
    input  logic                DReq,
    input  logic                DWe,
    input  logic [ADDR_LEN-1:0] DAddr,
    input  logic [31:0]         DWdata,
    output logic                DWready,
    output logic                DGnt,
    output logic [31:0]         DRdata,
    output logic                DRvalid,
    output logic                DDone,
    output logic                MemReq,
    output logic                MemWe,
    output logic [ADDR_LEN-1:0] MemAddr,
    output logic [31:0]         MemWdata,
    input  logic                MemAck,
    input  logic [31:0]         MemRdata,
    output logic                Busy
);

    localparam int   c_OFS    = LINE_WORDS_LOG + 2;
    localparam logic c_OWN_I  = 1'b0;
    localparam logic c_OWN_D  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_owner;
    logic                      r_we;
    logic [ADDR_LEN-1:c_OFS]   r_base;
    logic [LINE_WORDS_LOG-1:0] r_cnt;
    logic                      r_irvalid;
    logic                      r_drvalid;
    logic [31:0]               r_irdata;
    logic [31:0]               r_drdata;
    logic                      w_winner;
    logic                      w_rd_beat;
    logic                      w_unused;

    assign w_unused = ^{IAddr[c_OFS-1:0], DAddr[c_OFS-1:0]};

`ifdef MEM_ARB_RR_EN
    logic r_last;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_winner = DReq && !(IReq && (r_last == c_OWN_D));
    end

    always_ff @(posedge clk or negedge CpuRstN) begin
        if (!CpuRstN) begin
            r_last <= c_OWN_I;
        end else if ((r_state == S_IDLE) && (IReq || DReq)) begin
            r_last <= w_winner;
        end
    end
`else
    always_comb begin
        w_winner = DReq ? c_OWN_D : c_OWN_I;
    end
`endif

    always_ff @(posedge clk or negedge CpuRstN) begin
        if (!CpuRstN) begin
            r_state <= S_IDLE;
            r_owner <= c_OWN_I;
            r_we    <= 1'b0;
            r_base  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (IReq || DReq) begin
                        r_owner <= w_winner;
                        r_we    <= w_winner ? DWe : 1'b0;
                        r_base  <= w_winner ? DAddr[ADDR_LEN-1:c_OFS]
                                            : IAddr[ADDR_LEN-1:c_OFS];
                        r_cnt   <= '0;
                        r_state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (MemAck) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (&r_cnt) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_rd_beat = (r_state == S_BURST) && MemAck && !r_we;

    // Read words are returned one cycle after their MemAck.
    always_ff @(posedge clk or negedge CpuRstN) begin
        if (!CpuRstN) begin
            r_irvalid <= 1'b0;
            r_drvalid <= 1'b0;
            r_irdata  <= '0;
            r_drdata  <= '0;
        end else begin
            r_irvalid <= w_rd_beat && (r_owner == c_OWN_I);
            r_drvalid <= w_rd_beat && (r_owner == c_OWN_D);
            if (w_rd_beat && (r_owner == c_OWN_I)) begin
                r_irdata <= MemRdata;
            end
            if (w_rd_beat && (r_owner == c_OWN_D)) begin
                r_drdata <= MemRdata;
            end
        end
    end

    assign Busy     = (r_state != S_IDLE);
    assign IGnt     = Busy && (r_owner == c_OWN_I);
    assign DGnt     = Busy && (r_owner == c_OWN_D);
    assign IDone    = (r_state == S_DONE) && (r_owner == c_OWN_I);
    assign DDone    = (r_state == S_DONE) && (r_owner == c_OWN_D);
    assign MemReq   = (r_state == S_BURST);
    assign MemWe    = MemReq && r_we;
    assign MemAddr  = {r_base, r_cnt, 2'b00};
    assign MemWdata = DWdata;
    assign DWready  = MemAck && MemReq && (r_owner == c_OWN_D) && r_we;
    assign IRvalid  = r_irvalid;
    assign DRvalid  = r_drvalid;
    assign IRdata   = r_irdata;
    assign DRdata   = r_drdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_refill_arbiter
// Description : Scoreboard bench for mem_refill_arbiter; the expected burst
//               order comes from a queue-based arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_refill_arbiter;

    localparam int AL = 32;
    localparam int LW = 3;
    localparam int NW = 1 << LW;

    logic          clk = 1'b0;
    logic          CpuRstN = 1'b0;
    logic          IReq = 1'b0, DReq = 1'b0, DWe = 1'b0, MemAck = 1'b0;
    logic [AL-1:0] IAddr = '0, DAddr = '0;
    logic [31:0]   DWdata = '0, MemRdata = '0;
    logic          IGnt, IRvalid, IDone, DWready, DGnt, DRvalid, DDone;
    logic          MemReq, MemWe, Busy;
    logic [31:0]   IRdata, DRdata, MemWdata;
    logic [AL-1:0] MemAddr;

    mem_refill_arbiter #(.ADDR_LEN(AL), .LINE_WORDS_LOG(LW)) dut (
        .clk(clk), .CpuRstN(CpuRstN),
        .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IRdata(IRdata),
        .IRvalid(IRvalid), .IDone(IDone),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
        .DWready(DWready), .DGnt(DGnt), .DRdata(DRdata), .DRvalid(DRvalid),
        .DDone(DDone),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemAck(MemAck), .MemRdata(MemRdata), .Busy(Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { bit own; logic [31:0] base; bit we; } burst_t;
    typedef struct { bit own; logic [31:0] data; } rd_t;

    burst_t exp_q[$];
    rd_t    rdq[$];

    // Scoreboard state, owned by the monitor.
    bit            active = 0;
    bit            cur_own = 0;
    bit            cur_we = 0;
    logic [31:0]   cur_base = '0;
    int            word = 0;
    int            last_ack = 0;
    int            exp_gc = -1;
    burst_t        mb;
    rd_t           mr;
    logic [LW-1:0] wv;
    bit            pend;

    always @(negedge clk) begin
        if (!CpuRstN) begin
            active = 0;
            word   = 0;
            exp_gc = -1;
            rdq.delete();
            exp_q.delete();
        end else begin
            if (IGnt && DGnt) chk("gnt_overlap", 1, 0);
            if (IRvalid || DRvalid) begin
                if (IRvalid && DRvalid) chk("rvalid_both", 1, 0);
                if (rdq.size() == 0) begin
                    chk("rvalid_unexpected", {IRvalid, DRvalid}, 0);
                end else begin
                    mr = rdq.pop_front();
                    chk("rvalid_owner", DRvalid, mr.own);
                    chk("rdata", DRvalid ? DRdata : IRdata, mr.data);
                end
            end
            if (!active && (IGnt || DGnt)) begin
                if (exp_q.size() == 0) begin
                    chk("grant_unexpected", {IGnt, DGnt}, 0);
                end else begin
                    mb = exp_q.pop_front();
                    chk("grant_owner", DGnt, mb.own);
                    if (exp_gc >= 0) chk("grant_cycle", cyc, exp_gc);
                    exp_gc   = -1;
                    cur_own  = mb.own;
                    cur_base = mb.base;
                    cur_we   = mb.we;
                    word     = 0;
                    active   = 1;
                end
            end
            chk("dwready", DWready, active && MemReq && MemAck && cur_we && cur_own);
            if (active) begin
                chk("busy", Busy, 1);
                if (IDone || DDone) begin
                    chk("done_owner", DDone, cur_own);
                    chk("done_words", word, NW);
                    chk("done_cycle", cyc, last_ack + 1);
                    chk("done_memreq", MemReq, 0);
                    chk("done_rdq_empty", rdq.size(), 0);
                    pend = cur_own ? IReq : DReq;
                    if (pend) exp_gc = cyc + 2;
                    active = 0;
                end else begin
                    chk("memreq", MemReq, 1);
                    if (MemReq) begin
                        wv = word[LW-1:0];
                        chk("memaddr", MemAddr, {cur_base[AL-1:LW+2], wv, 2'b00});
                        chk("memwe", MemWe, cur_we);
                        if (MemAck) begin
                            if (cur_we) chk("memwdata", MemWdata, DWdata);
                            else rdq.push_back('{cur_own, MemRdata});
                            word++;
                            last_ack = cyc;
                        end
                    end
                end
            end else begin
                chk("idle_memreq", MemReq, 0);
                chk("idle_busy", Busy, 0);
                if (IDone || DDone) chk("done_unexpected", {IDone, DDone}, 0);
            end
        end
    end

    // Memory model: ack pattern chosen by the running test.
    int ack_mode  = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        MemRdata = $urandom;
        DWdata   = $urandom;
        case (ack_mode)
            0: MemAck = 1'b1;
            1: MemAck = cyc[0];
            2: MemAck = ($urandom_range(0, 2) != 0);
            default: begin
                if (active && word == 3 && stall_cnt < 5) begin
                    MemAck = 1'b0;
                    stall_cnt++;
                end else begin
                    MemAck = 1'b1;
                end
            end
        endcase
    end

    // Arbitration reference: 0 = I last granted, 1 = D.
    bit model_last = 0;

    task automatic run_txn(input bit ir, input logic [31:0] ia, input bit dr,
                           input bit dwe, input logic [31:0] da);
        bit first;
        bit idn, ddn;
        int n;
        if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
            first = !model_last;
`else
            first = 1;
`endif
            if (first) begin
                exp_q.push_back('{1, da, dwe});
                exp_q.push_back('{0, ia, 0});
            end else begin
                exp_q.push_back('{0, ia, 0});
                exp_q.push_back('{1, da, dwe});
            end
            model_last = !first;
        end else if (dr) begin
            exp_q.push_back('{1, da, dwe});
            model_last = 1;
        end else begin
            exp_q.push_back('{0, ia, 0});
            model_last = 0;
        end
        @(posedge clk); #1;
        IReq = ir; IAddr = ia; DReq = dr; DWe = dwe; DAddr = da;
        exp_gc = cyc + 1;
        idn = 0; ddn = 0; n = 0;
        while ((IReq || DReq) && n < 400) begin
            @(negedge clk);
            if (IDone) idn = 1;
            if (DDone) ddn = 1;
            @(posedge clk); #1;
            if (idn) IReq = 1'b0;
            if (ddn) DReq = 1'b0;
            n++;
        end
        if (n >= 400) begin
            chk("txn_timeout", {IReq, DReq}, 0);
            IReq = 1'b0; DReq = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("bursts_served", exp_q.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ignt"}, IGnt, 0);
        chk({tag, "_dgnt"}, DGnt, 0);
        chk({tag, "_memreq"}, MemReq, 0);
        chk({tag, "_memwe"}, MemWe, 0);
        chk({tag, "_memaddr"}, MemAddr, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_irvalid"}, IRvalid, 0);
        chk({tag, "_irdata"}, IRdata, 0);
        chk({tag, "_idone"}, IDone, 0);
        chk({tag, "_drvalid"}, DRvalid, 0);
        chk({tag, "_drdata"}, DRdata, 0);
        chk({tag, "_ddone"}, DDone, 0);
        chk({tag, "_dwready"}, DWready, 0);
    endtask

    initial begin
        int n;
        bit ir, dr;
        #12;
        chk_outputs_zero("reset");
        @(posedge clk); #1;
        CpuRstN = 1'b1;

        ack_mode = 0;
        run_txn(1, 32'h0000_1234, 0, 0, 32'h0);
        ack_mode = 1;
        run_txn(0, 32'h0, 1, 1, 32'h8000_0040);
        ack_mode = 0;
        run_txn(1, 32'h0000_1000, 1, 0, 32'h0000_2000);
        ack_mode = 2;
        run_txn(1, 32'h0000_3000, 1, 1, 32'h0000_4000);
        stall_cnt = 0;
        ack_mode = 3;
        run_txn(1, 32'h0000_5560, 0, 0, 32'h0);

        // Reset in the middle of a refill, then a fresh request.
        ack_mode = 0;
        exp_q.push_back('{0, 32'h0000_1234, 0});
        @(posedge clk); #1;
        IReq = 1'b1; IAddr = 32'h0000_1234;
        exp_gc = cyc + 1;
        n = 0;
        while (!(active && word == 3) && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 50) chk("reach_word3_timeout", n, 0);
        #1;
        CpuRstN = 1'b0;
        IReq = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        CpuRstN = 1'b1;
        model_last = 0;
        run_txn(1, 32'h0000_1220, 0, 0, 32'h0);

        ack_mode = 2;
        for (int i = 0; i < 20; i++) begin
            ir = $urandom_range(0, 1);
            dr = ir ? bit'($urandom_range(0, 1)) : 1'b1;
            run_txn(ir, $urandom, dr, bit'($urandom_range(0, 1)), $urandom);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Shares the single main-memory port between the instruction-cache and data-cache miss engines of the pipelined RISC-V CPU. Each requester asks for a whole-line burst: an ICache refill, a DCache refill, or a DCache dirty-line writeback. The arbiter picks one winner, sequences the word-by-word burst to memory, returns read data to the winner and signals completion. The `ICacheMiss`/`DCacheMiss` stall sources seen by the hazard logic stay asserted until the corresponding Done pulse.

## Interface
Parameters:
- `ADDR_LEN`, 32, byte-address width.
- `LINE_WORDS_LOG`, 3, log2 of 32-bit words per cache line (8 words by default).

Ports (direction, width, meaning):
- `clk`  in  1  system clock, rising edge.
- `CpuRstN`  in  1  reset, asynchronous, active-low.
- `IReq`  in  1  ICache line-refill request; held until `IDone`.
- `IAddr`  in  `ADDR_LEN`  ICache line address; low `LINE_WORDS_LOG+2` bits ignored.
- `IGnt`  out  1  ICache owns the memory port.
- `IRdata`  out  32  refill word to ICache.
- `IRvalid`  out  1  `IRdata` valid, one-cycle pulse per word.
- `IDone`  out  1  ICache burst complete, one-cycle pulse.
- `DReq`  in  1  DCache request; held until `DDone`.
- `DWe`  in  1  1 = writeback burst, 0 = refill burst; stable while `DReq` is high.
- `DAddr`  in  `ADDR_LEN`  DCache line address; low bits ignored.
- `DWdata`  in  32  writeback word currently offered.
- `DWready`  out  1  `DWdata` consumed this cycle; DCache advances its word pointer.
- `DGnt`  out  1  DCache owns the memory port.
- `DRdata`  out  32  refill word to DCache.
- `DRvalid`  out  1  `DRdata` valid, one-cycle pulse per word.
- `DDone`  out  1  DCache burst complete, one-cycle pulse.
- `MemReq`  out  1  word transfer requested.
- `MemWe`  out  1  write transfer.
- `MemAddr`  out  `ADDR_LEN`  word byte address.
- `MemWdata`  out  32  write data; combinationally equal to `DWdata`.
- `MemAck`  in  1  current word accepted (write) or `MemRdata` valid (read).
- `MemRdata`  in  32  read data, valid with `MemAck`.
- `Busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, BURST, DONE.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner and latch its owner ID, line base address and write flag (`DWe` for DCache, 0 for ICache).
  - Clear the word counter and go to BURST.
- **BURST**
  - `MemReq`=1 and `MemWe`=latched write flag.
  - `MemAddr` = {base[`ADDR_LEN`-1:`LINE_WORDS_LOG`+2], cnt, 2'b00}.
  - Each `MemAck` cycle completes one word and increments cnt.
  - On `MemAck` with cnt = all-ones, go to DONE. The counter wraps to 0; there is no address carry into the line base.
- **DONE**
  - Pulse the owner's Done output.
  - `MemReq`=0.
  - Return to IDLE.
  - Requests are ignored in this state. The requester drops Req on seeing Done.
- **Read data path:** `MemRdata` is registered into the owner's Rdata, and the owner's Rvalid is registered from `MemAck`.
- **Write data path:** `DWready` = `MemAck` & BURST & owner=D & write flag, combinational.
- **Grants:** `IGnt`/`DGnt` are high in BURST and DONE for the owner only. Both are never high together.
- **Arbitration without macro:** fixed priority, D over I.
- **Request dropped early:** a requester dropping Req mid-burst is a protocol violation. The burst completes regardless.
- **Reset values:** every output is 0, state is IDLE, cnt is 0, and the latched owner is I.
- **Asynchronous reset mid-burst:** outputs go to 0 immediately and the partial burst is abandoned. After release, a new request restarts at word 0.

## Timing
- Req high at edge k while in IDLE: BURST from k+1, with Gnt and `MemReq` high in cycle k+1.
- `MemAddr` changes only on the edge after a `MemAck`. It is held indefinitely while `MemAck`=0.
- Rvalid/Rdata appear one cycle after the matching `MemAck`.
- Last `MemAck` in cycle t:
  - cycle t+1: DONE, Done=1 and final Rvalid=1 in the same cycle.
  - cycle t+2: IDLE.
  - earliest next `MemReq`: cycle t+3.
- Minimum burst with `MemAck` tied high: 2^`LINE_WORDS_LOG` + 3 cycles from Req to the next possible grant.
- `MemWdata`/`DWready` have zero latency (combinational).

## Configuration
- `MEM_ARB_RR_EN`
  - **Defined:** round-robin arbitration. When both requesters are high in IDLE, the one not granted last wins. The last-granted register resets to I, so D wins the first tie.
  - **Undefined:** fixed D-over-I priority. The last-granted register is not instantiated.

## Test plan
- **ICache-only refill:** `IReq`=1, `IAddr`=0x0000_1234, `MemAck` tied 1 -> `MemAddr` 0x1220, 0x1224 … 0x123C; eight `IRvalid` pulses carrying `MemRdata`; `IDone` high for one cycle together with the 8th `IRvalid`; `MemWe`=0 throughout.
- **DCache writeback:** `DWe`=1, `DAddr`=0x8000_0040, `MemAck` high every other cycle -> `MemWe`=1; eight `DWready` pulses coinciding exactly with `MemAck`; `MemAddr` steps 0x8000_0040..0x8000_005C; `DDone`; no `DRvalid`.
- **Simultaneous requests, macro undefined:** `IReq` and `DReq` rise together -> D served first. `IGnt` rises 2 cycles after `DDone`, and `IGnt` never overlaps `DGnt`.
- **Simultaneous requests, `MEM_ARB_RR_EN` defined:** two consecutive ties -> grant order D, I, D, I.
- **Memory stall:** `MemAck` held low for 5 cycles at word 3 -> `MemAddr` frozen at base+0xC, no Rvalid pulses, `Busy`=1; the burst resumes normally.
- **Reset mid-burst:** `CpuRstN` asserted at word 3 -> all outputs 0 asynchronously. After release, re-request `IAddr`=0x1220 -> the first `MemAddr` is 0x1220.
